cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_store.sv | 65 ++++++
 rtl/cache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the read-only direct-mapped cache.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_MISS   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int ADDR_W_DEF  = 15;
   localparam int INDEX_W_DEF = 8;
   localparam int OFFSET_W    = 2;
   localparam int LINE_WORDS  = 4;
   localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W;

endpackage

// File: rtl/cache_store.sv
// Tag, valid and data arrays: one combinational line read port, one full-line write port.
module cache_store
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [31:0]        rd_line [0:LINE_WORDS-1],
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_line [0:LINE_WORDS-1]
);

   localparam int LINES = 1 << INDEX_W;

   logic [TAG_W-1:0] tag_mem  [0:LINES-1];
   logic [31:0]      data_mem [0:LINES-1][0:LINE_WORDS-1];
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] valid_d;

   // Line read port.
   always_comb begin
      rd_valid = valid_q[rd_index];
      rd_tag   = tag_mem[rd_index];
      for (int w = 0; w < LINE_WORDS; w++) begin
         rd_line[w] = data_mem[rd_index][w];
      end
   end

   // Next valid vector.
   always_comb begin
      valid_d = valid_q;
      if (wr_en) begin
         valid_d[wr_index] = 1'b1;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bits are the only array state cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         tag_mem[wr_index] <= wr_tag;
         for (int w = 0; w < LINE_WORDS; w++) begin
            data_mem[wr_index][w] <= wr_line[w];
         end
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Read-only direct-mapped cache controller with block refill from dataMem.
// Optional macro CACHE_STATS_EN adds 16-bit hit/miss counters.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INDEX_W = INDEX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data [0:LINE_WORDS-1],
   input  logic              mem_rdy
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic              cpu_hit_q, cpu_hit_d;
   logic              mem_read_q, mem_read_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [2:0]        rdy_sync_q, rdy_sync_d;
   logic              rdy_rise_s;
   logic              wr_en_s;
   logic              rd_valid_s;
   logic [TAG_W-1:0]  rd_tag_s;
   logic [31:0]       rd_line_s [0:LINE_WORDS-1];
`ifdef CACHE_STATS_EN
   logic [15:0]       hit_cnt_q, hit_cnt_d;
   logic [15:0]       miss_cnt_q, miss_cnt_d;
`endif

   cache_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W]),
      .rd_valid (rd_valid_s),
      .rd_tag   (rd_tag_s),
      .rd_line  (rd_line_s),
      .wr_en    (wr_en_s),
      .wr_index (addr_q[INDEX_W+OFFSET_W-1:OFFSET_W]),
      .wr_tag   (addr_q[ADDR_W-1:INDEX_W+OFFSET_W]),
      .wr_line  (mem_data)
   );

   // [0],[1] synchronize mem_rdy; [2] is the previous synchronized level for edge detection.
   assign rdy_sync_d = {rdy_sync_q[1:0], mem_rdy};
   assign rdy_rise_s = rdy_sync_q[1] & ~rdy_sync_q[2];

   // Lookup is resolved at the acceptance edge so the hit response is registered into LOOKUP.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cpu_rdata_d = 32'd0;
      cpu_ready_d = 1'b0;
      cpu_hit_d   = 1'b0;
      mem_read_d  = mem_read_q;
      mem_addr_d  = mem_addr_q;
      wr_en_s     = 1'b0;
`ifdef CACHE_STATS_EN
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               state_d = ST_LOOKUP;
               if (rd_valid_s && (rd_tag_s == cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W])) begin
                  cpu_ready_d = 1'b1;
                  cpu_hit_d   = 1'b1;
                  cpu_rdata_d = rd_line_s[cpu_addr[OFFSET_W-1:0]];
               end else begin
                  cpu_ready_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (cpu_hit_q) begin
               state_d = ST_IDLE;
`ifdef CACHE_STATS_EN
               hit_cnt_d = hit_cnt_q + 16'd1;
`endif
            end else begin
               state_d    = ST_MISS;
               mem_read_d = 1'b1;
               mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], 2'b00};
`ifdef CACHE_STATS_EN
               miss_cnt_d = miss_cnt_q + 16'd1;
`endif
            end
         end
         ST_MISS: begin
            if (rdy_rise_s) begin
               wr_en_s     = 1'b1;
               mem_read_d  = 1'b0;
               mem_addr_d  = '0;
               cpu_ready_d = 1'b1;
               cpu_rdata_d = mem_data[addr_q[OFFSET_W-1:0]];
               state_d     = ST_RESP;
            end else begin
               state_d = ST_MISS;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            mem_read_d = 1'b0;
            mem_addr_d = '0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cpu_rdata_q <= 32'd0;
         cpu_ready_q <= 1'b0;
         cpu_hit_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_addr_q  <= '0;
         rdy_sync_q  <= 3'b000;
`ifdef CACHE_STATS_EN
         hit_cnt_q   <= 16'd0;
         miss_cnt_q  <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_hit_q   <= cpu_hit_d;
         mem_read_q  <= mem_read_d;
         mem_addr_q  <= mem_addr_d;
         rdy_sync_q  <= rdy_sync_d;
`ifdef CACHE_STATS_EN
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
`endif
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign cpu_hit   = cpu_hit_q;
   assign mem_read  = mem_read_q;
   assign mem_addr  = mem_addr_q;
`ifdef CACHE_STATS_EN
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl; dataMem returns word value == word address.
module tb_cache_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic [14:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_hit;
   logic        mem_read;
   logic [14:0] mem_addr;
   logic [31:0] mem_data [0:3];
   logic        mem_rdy;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   cache_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_hit   (cpu_hit),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_rdy   (mem_rdy)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [14:0] a);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      @(posedge clk);
      #1 cpu_req = 1'b0;
   endtask

   task automatic read_hit(input string tag, input logic [14:0] a, input logic [31:0] exp_data);
      issue(a);
      @(negedge clk);
      chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
      chk({tag, "_hit"}, {31'd0, cpu_hit}, 32'd1);
      chk({tag, "_rdata"}, cpu_rdata, exp_data);
      chk({tag, "_memread"}, {31'd0, mem_read}, 32'd0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, {31'd0, cpu_ready}, 32'd0);
   endtask

   // Miss with refill; a stale-high mem_rdy must first fall before a new rise is honoured.
   task automatic read_miss(input string tag, input logic [14:0] a, input logic [14:0] exp_blk,
                            input logic [31:0] exp_data, input bit leave_high);
      int n;
      issue(a);
      @(negedge clk);
      chk({tag, "_lookup_ready"}, {31'd0, cpu_ready}, 32'd0);
      @(negedge clk);
      chk({tag, "_memread"}, {31'd0, mem_read}, 32'd1);
      chk({tag, "_memaddr"}, {17'd0, mem_addr}, {17'd0, exp_blk});
      for (int i = 0; i < 4; i++) begin
         mem_data[i] = {17'd0, exp_blk} + i;
      end
      if (mem_rdy) begin
         repeat (6) @(negedge clk);
         chk({tag, "_stale_ignored"}, {30'd0, cpu_ready, mem_read}, 32'd1);
         chk({tag, "_addr_stable"}, {17'd0, mem_addr}, {17'd0, exp_blk});
         mem_rdy = 1'b0;
         repeat (3) @(negedge clk);
      end
      mem_rdy = 1'b1;
      n = 0;
      while (cpu_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, {31'd0, (n < 20)}, 32'd1);
      chk({tag, "_hit"}, {31'd0, cpu_hit}, 32'd0);
      chk({tag, "_rdata"}, cpu_rdata, exp_data);
      chk({tag, "_memread_drop"}, {31'd0, mem_read}, 32'd0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, {31'd0, cpu_ready}, 32'd0);
      if (!leave_high) mem_rdy = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = 15'd0;
      mem_rdy  = 1'b0;
      for (int i = 0; i < 4; i++) mem_data[i] = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_hit", {31'd0, cpu_hit}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_memread", {31'd0, mem_read}, 32'd0);
      chk("rst_memaddr", {17'd0, mem_addr}, 32'd0);
      rst_n = 1'b1;

      read_miss("m0005", 15'h0005, 15'h0004, 32'h0000_0005, 1'b0);
      read_hit("h0006", 15'h0006, 32'h0000_0006);
      read_miss("m0405", 15'h0405, 15'h0404, 32'h0000_0405, 1'b0);
`ifdef CACHE_STATS_EN
      chk("stats_hit", {16'd0, hit_cnt}, 32'd1);
      chk("stats_miss", {16'd0, miss_cnt}, 32'd2);
`endif
      read_hit("h0407", 15'h0407, 32'h0000_0407);
      read_miss("re0005", 15'h0005, 15'h0004, 32'h0000_0005, 1'b1);
      // mem_rdy left high across IDLE; next miss must wait for a fresh rise.
      read_miss("stale0023", 15'h0023, 15'h0020, 32'h0000_0023, 1'b0);
      read_hit("h0020", 15'h0020, 32'h0000_0020);
      read_hit("h0004", 15'h0004, 32'h0000_0004);

      // Reset in the middle of a miss.
      issue(15'h0010);
      @(negedge clk);
      @(negedge clk);
      chk("rm_memread_before", {31'd0, mem_read}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rm_memread_drop", {31'd0, mem_read}, 32'd0);
      chk("rm_memaddr_zero", {17'd0, mem_addr}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) mem_data[i] = 32'hDEAD_0000 + i;
      mem_rdy = 1'b1;
      repeat (5) @(negedge clk);
      chk("rm_rdy_ignored", {30'd0, cpu_ready, mem_read}, 32'd0);
      mem_rdy = 1'b0;
      repeat (3) @(negedge clk);
      read_miss("re0010", 15'h0010, 15'h0010, 32'h0000_0010, 1'b0);
      read_miss("post_rst0006", 15'h0006, 15'h0004, 32'h0000_0006, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
